stage_seq: RTL and testbench
============================

# stage_seq

Multi-cycle stage sequencer for the MIPS core. It steps each instruction through IF, ID, EX, MEM and WB, and decides which of those stages the instruction actually needs from the decoded control signals of `ctrl`. It produces the write strobes (PC, IR, register file, data memory) and handshakes with a variable-latency memory port. It sits between `ctrl` and the datapath, gating the level signals that `ctrl` decodes.

## Interface
Parameters:
- `MAX_WAIT`, default 16: maximum request cycles a memory access may take before it is declared a timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `run`  in  1  enables sequencing; sampled only when the next stage would be IF.
- `RegWr`, `MemWr`, `MemToReg`, `Branch`, `Jump`, `Link`  in  1 each  decoded controls from `ctrl`; valid from ID onward.
- `mem_ack`  in  1  memory access complete; meaningful only while a request is high.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data access request.
- `IRWr`  out  1  load the instruction register.
- `PCWr`  out  1  update PC; the fetcher selects the next-PC source.
- `RegWrEn`  out  1  gated register-file write.
- `MemWrEn`  out  1  gated data-memory write.
- `stage`  out  3  current state code.
- `busy`  out  1  state is neither IDLE nor HALT.
- `timeout_err`  out  1  sticky memory-timeout flag.
- `retired`  out  32  count of retired instructions.

## Operation
- States and codes: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
- "next" means IF if `run`=1, otherwise IDLE.
- IDLE: go to IF when `run`=1.
- IF: `imem_req`=1. When `mem_ack` arrives, `IRWr`=1 in that same cycle and the state moves to ID.
- ID: one cycle, always moves to EX.
- EX: one cycle. Priority order:
  - `Branch`, or `Jump` with `Link`=0: `PCWr`=1, go to next.
  - `MemToReg` or `MemWr`: go to MEM.
  - `RegWr` (this includes jal): go to WB.
  - Otherwise: `PCWr`=1, go to next.
- MEM: `dmem_req`=1 and `MemWrEn`=`MemWr`, both held until `mem_ack`. On ack:
  - load (`MemToReg`): go to WB.
  - store: `PCWr`=1, go to next.
- WB: one cycle with `RegWrEn`=1 and `PCWr`=1, then go to next.
- `retired` increments by 1 in every cycle where `PCWr`=1 and wraps modulo 2^32.
- Wait timer:
  - Counts consecutive request cycles in IF or MEM and clears whenever a request ends.
  - If `mem_ack` is still low on the MAX_WAIT-th request cycle, the next state is HALT.
- HALT: all strobes and requests are 0, `timeout_err`=1. HALT is left only by reset.
- `run` falling mid-instruction does not abort it; the instruction completes and the sequencer then enters IDLE.
- `mem_ack` with no request is ignored.

## Timing
- All strobes are combinational from state and `mem_ack`. State, timer, `retired` and `timeout_err` are registered.
- Reset, asserted at any time: state=IDLE, timer=0, `retired`=0, `timeout_err`=0. All outputs are therefore 0 and `stage`=0.
- Cycles per instruction with zero memory wait (ack in the first request cycle):
  - ALU or jal: 4 (IF, ID, EX, WB).
  - load: 5.
  - store: 4.
  - branch or j: 3.
- Each additional wait cycle adds 1 cycle.
- IF follows the retiring cycle back-to-back, with no bubble.
- On a write, the register file and data memory sample their inputs at the clock edge ending the strobe cycle.

## Structure
- State codes live in a shared constants header included by `mips`, `stage_seq` and the benches.
- One sub-module, `wait_timer`, holds the request counter and exposes `clear`, `count_en` and `expired`. It is sized by `MAX_WAIT`, with width $clog2(MAX_WAIT+1).

## Test plan
- ALU instruction, `RegWr`=1, `mem_ack` held at 1, `run`=1 after reset → `stage` sequence 1,2,3,5. `RegWrEn`=`PCWr`=1 in cycle 4 only, then `retired`=1 and IF restarts.
- Load with data ack delayed 3 cycles → `dmem_req` high for 4 cycles with `MemWrEn`=0, then WB. 8 cycles total, and `RegWrEn` pulses exactly once.
- Store (`MemWr`=1) → `MemWrEn`=1 only while `dmem_req`=1. `PCWr` fires on the ack cycle, with no `RegWrEn` and no WB.
- beq (`Branch`=1) → `PCWr` in EX at cycle 3, MEM and WB never entered. Jal (`Jump`=`Link`=`RegWr`=1) → WB is taken.
- `mem_ack` held at 0 with `MAX_WAIT`=16 → `imem_req` high for 16 cycles, then HALT. `timeout_err`=1, all strobes 0, and `run` toggling has no effect until reset.
- `run` dropped during MEM of a load → WB completes, then IDLE with `busy`=0. Separately, `rst` asserted mid-MEM → immediately IDLE with all outputs 0 and `retired`=0.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// Shared constants for the multi-cycle stage sequencer: state codes and the
// small helper that picks where an instruction goes once it retires.
package stage_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } stage_e;

  // After the retiring cycle the next fetch starts back-to-back if run is
  // still high; otherwise the sequencer parks in IDLE.
  function automatic stage_e next_after_retire(input logic run);
    return run ? ST_IF : ST_IDLE;
  endfunction

endpackage

// File: rtl/stage_seq_wait_timer.sv
// Consecutive memory-request cycle counter. expired is high during the
// MAX_WAIT-th request cycle of an access, so a missing ack in that cycle
// can be turned into a timeout by the sequencer.
module wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_count;

  // Count request cycles without ack; any cycle that ends a request clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // r_count holds the number of earlier request cycles in this access.
  assign expired = (r_count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/stage_seq.sv
// Multi-cycle stage sequencer: walks each instruction through IF/ID/EX/MEM/WB,
// skipping stages the decoded controls do not need, and generates the PC, IR,
// register-file and data-memory strobes.
//
// Memory handshake: a request (imem_req in IF, dmem_req in MEM) stays high
// until the cycle in which mem_ack is seen high; that cycle completes the
// access. mem_ack outside a request cycle is ignored.
module stage_seq
  import stage_seq_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        RegWr,
  input  logic        MemWr,
  input  logic        MemToReg,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Link,
  input  logic        mem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        IRWr,
  output logic        PCWr,
  output logic        RegWrEn,
  output logic        MemWrEn,
  output logic [2:0]  stage,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] retired
);

  stage_e      r_state;
  stage_e      w_next;
  logic        r_timeout_err;
  logic [31:0] r_retired;
  logic        w_req;
  logic        w_expired;

  assign w_req = imem_req | dmem_req;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (~w_req | mem_ack),
    .count_en (w_req & ~mem_ack),
    .expired  (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode from the current stage and mem_ack.
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    RegWrEn  = 1'b0;
    MemWrEn  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_IF;
      end
      ST_IF: begin
        imem_req = 1'b1;
        if (mem_ack) begin
          IRWr   = 1'b1;
          w_next = ST_ID;
        end else if (w_expired) begin
          w_next = ST_HALT;
        end
      end
      ST_ID: begin
        w_next = ST_EX;
      end
      ST_EX: begin
        // Branch and plain jump retire here; jal needs WB for the link write.
        if (Branch || (Jump && !Link)) begin
          PCWr   = 1'b1;
          w_next = next_after_retire(run);
        end else if (MemToReg || MemWr) begin
          w_next = ST_MEM;
        end else if (RegWr) begin
          w_next = ST_WB;
        end else begin
          PCWr   = 1'b1;
          w_next = next_after_retire(run);
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        MemWrEn  = MemWr;
        if (mem_ack) begin
          if (MemToReg) begin
            w_next = ST_WB;
          end else begin
            PCWr   = 1'b1;
            w_next = next_after_retire(run);
          end
        end else if (w_expired) begin
          w_next = ST_HALT;
        end
      end
      ST_WB: begin
        RegWrEn = 1'b1;
        PCWr    = 1'b1;
        w_next  = next_after_retire(run);
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Sticky timeout flag, raised together with the move into HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_next == ST_HALT) begin
      r_timeout_err <= 1'b1;
    end
  end

  // Retired-instruction counter: one per PC update, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= '0;
    end else if (PCWr) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign stage       = r_state;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign timeout_err = r_timeout_err;
  assign retired     = r_retired;

endmodule

// File: tb/tb_stage_seq.sv
// Bench for stage_seq: random instruction stream against a per-instruction
// cycle-trace model, plus directed run-drop, mid-MEM reset and timeout steps.
module tb_stage_seq;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam int K_J     = 4;
  localparam int K_JAL   = 5;
  localparam int K_NOP   = 6;

  logic        clk;
  logic        rst;
  logic        run;
  logic        RegWr, MemWr, MemToReg, Branch, Jump, Link;
  logic        mem_ack;
  logic        imem_req, dmem_req, IRWr, PCWr, RegWrEn, MemWrEn;
  logic [2:0]  stage;
  logic        busy, timeout_err;
  logic [31:0] retired;

  int          errors;
  int          checks;
  logic [31:0] exp_retired;

  stage_seq #(.MAX_WAIT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .RegWr       (RegWr),
    .MemWr       (MemWr),
    .MemToReg    (MemToReg),
    .Branch      (Branch),
    .Jump        (Jump),
    .Link        (Link),
    .mem_ack     (mem_ack),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .IRWr        (IRWr),
    .PCWr        (PCWr),
    .RegWrEn     (RegWrEn),
    .MemWrEn     (MemWrEn),
    .stage       (stage),
    .busy        (busy),
    .timeout_err (timeout_err),
    .retired     (retired)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output record: {stage, imem, dmem, irwr, pcwr, rwe, mwe, busy, terr}.
  function automatic logic [10:0] rec(input logic [2:0] st, input logic imem,
                                      input logic dmem, input logic irwr,
                                      input logic pcwr, input logic rwe,
                                      input logic mwe, input logic bsy,
                                      input logic terr);
    return {st, imem, dmem, irwr, pcwr, rwe, mwe, bsy, terr};
  endfunction

  task automatic check_cycle(input logic [10:0] exp, input string tag);
    logic [10:0] obs;
    obs = {stage, imem_req, dmem_req, IRWr, PCWr, RegWrEn, MemWrEn, busy, timeout_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: outputs=%b required=%b", tag, obs, exp);
    end
    checks++;
    assert (retired === exp_retired) else begin
      errors++;
      $error("FAIL %s_retired: retired=%0d required=%0d", tag, retired, exp_retired);
    end
    if (exp[4]) exp_retired = exp_retired + 32'd1;
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r < 9) return $urandom_range(1, 3);
    return 15;
  endfunction

  // Driver plus model: builds the expected trace for one instruction from its
  // class and wait counts, then drives it cycle by cycle.
  task automatic run_instr(input int kind, input int fw, input int dw, input bit drop);
    logic [10:0] eq[$];
    logic        aq[$];
    logic        c_rw, c_mw, c_mr, c_br, c_j, c_l;
    logic        pc_in_ex, uses_mem, uses_wb, is_store;
    string       tag;
    c_rw = 1'b0; c_mw = 1'b0; c_mr = 1'b0; c_br = 1'b0; c_j = 1'b0; c_l = 1'b0;
    case (kind)
      K_ALU:   c_rw = 1'b1;
      K_LOAD:  begin c_rw = 1'b1; c_mr = 1'b1; end
      K_STORE: c_mw = 1'b1;
      K_BR:    begin c_br = 1'b1; c_rw = 1'($urandom_range(0, 1)); c_mw = 1'($urandom_range(0, 1)); end
      K_J:     c_j = 1'b1;
      K_JAL:   begin c_j = 1'b1; c_l = 1'b1; c_rw = 1'b1; end
      default: ;
    endcase
    uses_mem = (kind == K_LOAD) || (kind == K_STORE);
    is_store = (kind == K_STORE);
    uses_wb  = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JAL);
    pc_in_ex = (kind == K_BR) || (kind == K_J) || (kind == K_NOP);
    for (int i = 0; i <= fw; i++) begin
      eq.push_back(rec(3'd1, 1'b1, 1'b0, 1'(i == fw), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      aq.push_back(1'(i == fw));
    end
    eq.push_back(rec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    aq.push_back(1'($urandom_range(0, 1)));
    eq.push_back(rec(3'd3, 1'b0, 1'b0, 1'b0, pc_in_ex, 1'b0, 1'b0, 1'b1, 1'b0));
    aq.push_back(1'($urandom_range(0, 1)));
    if (uses_mem) begin
      for (int i = 0; i <= dw; i++) begin
        eq.push_back(rec(3'd4, 1'b0, 1'b1, 1'b0, 1'(is_store && (i == dw)), 1'b0, is_store, 1'b1, 1'b0));
        aq.push_back(1'(i == dw));
      end
    end
    if (uses_wb) begin
      eq.push_back(rec(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      aq.push_back(1'($urandom_range(0, 1)));
    end
    for (int idx = 0; idx < eq.size(); idx++) begin
      @(negedge clk);
      if (idx <= fw) begin
        RegWr    = 1'($urandom_range(0, 1));
        MemWr    = 1'($urandom_range(0, 1));
        MemToReg = 1'($urandom_range(0, 1));
        Branch   = 1'($urandom_range(0, 1));
        Jump     = 1'($urandom_range(0, 1));
        Link     = 1'($urandom_range(0, 1));
      end else begin
        RegWr = c_rw; MemWr = c_mw; MemToReg = c_mr;
        Branch = c_br; Jump = c_j; Link = c_l;
      end
      mem_ack = aq[idx];
      if (drop && (eq[idx][10:8] == 3'd4)) run = 1'b0;
      tag = $sformatf("k%0d_fw%0d_dw%0d_c%0d", kind, fw, dw, idx);
      #1 check_cycle(eq[idx], tag);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_retired = 32'd0;
    rst = 1'b0; run = 1'b0; mem_ack = 1'b0;
    RegWr = 1'b0; MemWr = 1'b0; MemToReg = 1'b0;
    Branch = 1'b0; Jump = 1'b0; Link = 1'b0;

    // Reset holds everything at zero even with run and ack high.
    repeat (2) @(negedge clk);
    run = 1'b1; mem_ack = 1'b1;
    #1 check_cycle(rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_hold");
    @(negedge clk);
    rst = 1'b1; run = 1'b1; mem_ack = 1'b0;
    #1 check_cycle(rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "idle_start");

    // Directed opening (ALU, delayed load, store, beq, jal), then random stream.
    run_instr(K_ALU, 0, 0, 1'b0);
    run_instr(K_LOAD, 0, 3, 1'b0);
    run_instr(K_STORE, 0, 1, 1'b0);
    run_instr(K_BR, 0, 0, 1'b0);
    run_instr(K_JAL, 0, 0, 1'b0);
    run_instr(K_ALU, 15, 0, 1'b0);
    run_instr(K_LOAD, 0, 15, 1'b0);
    for (int n = 0; n < 30; n++) begin
      int kind, fw, dw;
      kind = $urandom_range(0, 6);
      fw = pick_wait();
      dw = pick_wait();
      run_instr(kind, fw, dw, 1'b0);
    end

    // run dropped during MEM of a load: WB completes, then IDLE.
    run_instr(K_LOAD, 0, 2, 1'b1);
    @(negedge clk);
    mem_ack = 1'b1;
    #1 check_cycle(rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "drop_idle0");
    @(negedge clk);
    run = 1'b1; mem_ack = 1'b0;
    #1 check_cycle(rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "drop_idle1");

    // Load stalled in MEM, then asynchronous reset mid-cycle.
    @(negedge clk);
    RegWr = 1'b1; MemToReg = 1'b1; MemWr = 1'b0; Branch = 1'b0; Jump = 1'b0; Link = 1'b0;
    mem_ack = 1'b1;
    #1 check_cycle(rec(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "rst_if");
    @(negedge clk);
    mem_ack = 1'b0;
    #1 check_cycle(rec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "rst_id");
    @(negedge clk);
    #1 check_cycle(rec(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "rst_ex");
    @(negedge clk);
    #1 check_cycle(rec(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "rst_mem");
    #1 rst = 1'b0;
    exp_retired = 32'd0;
    #1 check_cycle(rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_mid_mem");
    @(negedge clk);
    #1 check_cycle(rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_mid_mem_hold");

    // Fetch never acknowledged: 16 request cycles, then HALT until reset.
    @(negedge clk);
    rst = 1'b1; run = 1'b1; mem_ack = 1'b0;
    #1 check_cycle(rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "to_idle");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1 check_cycle(rec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), $sformatf("to_if%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      RegWr = 1'($urandom_range(0, 1));
      MemWr = 1'($urandom_range(0, 1));
      #1 check_cycle(rec(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), $sformatf("halt%0d", i));
    end

    // Final report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
